mc_datapath: RTL and testbench

Parametrised multicycle datapath with an internal step sequencer, replacing the single-cycle datapath for memory systems that cannot answer in zero wait states. It owns PC, IR, MDR, A/B operand latches, ALUOut, the register file and the ALU instance. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared valid/ready memory port. Control decode stays in the existing controller, which sees `opcode` and returns per-instruction class/control signals.

---
 rtl/mc_datapath_if.sv | 7 +
 rtl/mc_datapath.sv | 109 ++++++++++
 tb/tb_mc_datapath.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// mc_datapath_if: shared valid/ready memory port between the datapath and memory
interface mc_datapath_if #(parameter int N = 32) ();
  logic req, we, ready;
  logic [N-1:0] addr, wdata, rdata;
  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle FETCH/DECODE/EXEC/MEM/WB datapath over one memory port; MC_DATAPATH_PERF_EN enables perf counters
module mc_datapath #(
  parameter int N = 32,
  parameter int RA_W = 7,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  mc_datapath_if.master mem,
  output logic [5:0] opcode,
  input  logic regwrite, memtoreg, memwrite, alusrc, regdst, branch, jump, jr, jal,
  input  logic [3:0] alucontrol,
  output logic retire,
  output logic [N-1:0] pc,
  output logic [31:0] perf_instrs, perf_stalls
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
  logic [2:0] state;
  logic [31:0] ir;
  logic [N-1:0] mdr, a, b, simm, aluout, alu_b, alu_y, rs_v, rt_v, rf_wd;
  logic [N-1:0] rf [2**RA_W];
  logic [RA_W-1:0] rs, rt, rd, rf_wa;
  logic fe, ex, mm, wb, done, rf_we;
  assign opcode = ir[31:26];
  assign rs = ir[19 +: RA_W];
  assign rt = ir[12 +: RA_W];
  assign rd = ir[5 +: RA_W];
  assign fe = state == S_FETCH;
  assign ex = state == S_EXEC;
  assign mm = state == S_MEM;
  assign wb = state == S_WB;
  assign mem.req = ~reset & (fe | mm);
  assign mem.we = mm & memwrite;
  assign mem.addr = mm ? aluout : pc;
  assign mem.wdata = b;
  // ALU: 0000 and, 0001 or, 0011 xor, 0100 nor, 0110 sub, 0111 signed slt, anything else add
  always_comb begin
    alu_b = alusrc ? simm : b;
    alu_y = alucontrol == 4'b0000 ? a & alu_b :
            alucontrol == 4'b0001 ? a | alu_b :
            alucontrol == 4'b0011 ? a ^ alu_b :
            alucontrol == 4'b0100 ? ~(a | alu_b) :
            alucontrol == 4'b0110 ? a - alu_b :
            alucontrol == 4'b0111 ? {{(N-1){1'b0}}, $signed(a) < $signed(alu_b)} :
            a + alu_b;
  end
  // control-transfer exits, retire pulse and the single register-file write port
  always_comb begin
    done = ex & (jr | jump | branch);
    retire = ~reset & (done | (mm & mem.ready & memwrite) | wb);
    rf_we = (ex & ~jr & jump & jal) | (wb & regwrite);
    rf_wa = ex ? '1 : regdst ? rd : rt;
    rf_wd = ex ? pc : memtoreg ? mdr : aluout;
    rs_v = rs == '0 ? '0 : rf[rs];
    rt_v = rt == '0 ? '0 : rf[rt];
  end
  // step sequencer and architectural state; reset wins over a completing transfer
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      mdr <= '0;
      a <= '0;
      b <= '0;
      simm <= '0;
      aluout <= '0;
      for (int i = 0; i < 2**RA_W; i++) rf[i] <= '0;
    end else begin
      if (rf_we && rf_wa != '0) rf[rf_wa] <= rf_wd;
      case (state)
        S_FETCH: if (mem.ready) begin
          ir <= mem.rdata[31:0];
          pc <= pc + N'(4);
          state <= S_DECODE;
        end
        S_DECODE: begin
          a <= rs_v;
          b <= rt_v;
          simm <= {{(N-12){ir[11]}}, ir[11:0]};
          state <= S_EXEC;
        end
        S_EXEC: begin
          aluout <= alu_y;
          pc <= jr ? a : jump ? {pc[N-1:28], ir[25:0], 2'b00} : (branch && alu_y == '0) ? pc + (simm << 2) : pc;
          state <= done ? S_FETCH : (memtoreg | memwrite) ? S_MEM : S_WB;
        end
        S_MEM: if (mem.ready) begin
          if (!memwrite) mdr <= mem.rdata;
          state <= memwrite ? S_FETCH : S_WB;
        end
        default: state <= S_FETCH;
      endcase
    end
`ifdef MC_DATAPATH_PERF_EN
  // retired-instruction and memory-wait-cycle counters, wrapping at 2**32
  always_ff @(posedge clk)
    if (reset) begin
      perf_instrs <= '0;
      perf_stalls <= '0;
    end else begin
      perf_instrs <= perf_instrs + {31'd0, retire};
      perf_stalls <= perf_stalls + {31'd0, mem.req & ~mem.ready};
    end
`else
  assign perf_instrs = '0;
  assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed program run through mc_datapath with a wait-state memory and controller model
module tb_mc_datapath;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  mc_datapath_if #(.N(32)) bus ();
  logic [5:0] opcode;
  logic regwrite, memtoreg, memwrite, alusrc, regdst, branch, jump, jr, jal, retire;
  logic [3:0] alucontrol;
  logic [31:0] pc, perf_instrs, perf_stalls;
  int vec = 0, miscmp = 0;
  logic [31:0] imem [1024];
  int fetch_waits = 0, data_waits = 0, cnt = 0, st_cnt = 0;
  logic force_rdy = 1'b0, nxt_fetch = 1'b1;
  logic [31:0] st_addr = '0, st_data = '0;
  localparam logic [5:0] OP_R = 6'd0, OP_J = 6'd2, OP_JAL = 6'd3, OP_BEQ = 6'd4, OP_ADDI = 6'd8, OP_JR = 6'd9, OP_LW = 6'd35, OP_SW = 6'd43;
`ifdef MC_DATAPATH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  mc_datapath #(.N(32), .RA_W(7), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .mem(bus), .opcode(opcode),
    .regwrite(regwrite), .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc), .regdst(regdst),
    .branch(branch), .jump(jump), .jr(jr), .jal(jal), .alucontrol(alucontrol),
    .retire(retire), .pc(pc), .perf_instrs(perf_instrs), .perf_stalls(perf_stalls)
  );
  // controller model
  always_comb begin
    regwrite = opcode inside {OP_R, OP_ADDI, OP_LW};
    memtoreg = opcode == OP_LW;
    memwrite = opcode == OP_SW;
    alusrc = opcode inside {OP_ADDI, OP_LW, OP_SW};
    regdst = opcode == OP_R;
    branch = opcode == OP_BEQ;
    jump = opcode inside {OP_J, OP_JAL};
    jal = opcode == OP_JAL;
    jr = opcode == OP_JR;
    alucontrol = opcode == OP_BEQ ? 4'b0110 : 4'b0010;
  end
  // memory model: separate wait counts for fetches and data transfers
  always_comb begin
    bus.ready = force_rdy | (bus.req & (cnt >= (nxt_fetch ? fetch_waits : data_waits)));
    bus.rdata = imem[bus.addr[11:2]];
  end
  always @(posedge clk) begin
    if (reset) begin
      cnt <= 0;
      nxt_fetch <= 1'b1;
    end else begin
      cnt <= (bus.req & ~bus.ready) ? cnt + 1 : 0;
      if (retire) nxt_fetch <= 1'b1;
      else if (bus.req & bus.ready) nxt_fetch <= 1'b0;
    end
    if (bus.req & bus.ready & bus.we) begin
      st_cnt <= st_cnt + 1;
      st_addr <= bus.addr;
      st_data <= bus.wdata;
    end
  end
  function automatic logic [31:0] ei(logic [5:0] op, logic [6:0] s, logic [6:0] t, logic [11:0] imm);
    return {op, s, t, imm};
  endfunction
  function automatic logic [31:0] er(logic [6:0] s, logic [6:0] t, logic [6:0] d);
    return {OP_R, s, t, d, 5'd0};
  endfunction
  function automatic logic [31:0] ej(logic [5:0] op, logic [25:0] tg);
    return {op, tg};
  endfunction
  task automatic run(output int cyc, output logic [31:0] fa);
    logic r;
    cyc = -1;
    fa = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) fa = bus.req ? bus.addr : 32'hx;
      r = retire;
      @(posedge clk); #1;
      if (r) begin
        cyc = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec++; if (bus.req !== 1'b0) begin miscmp++; $display("FAIL reset_req got %b want 0", bus.req); end
    vec++; if (pc !== 32'h100) begin miscmp++; $display("FAIL reset_pc got %h want 00000100", pc); end
    vec++; if (retire !== 1'b0) begin miscmp++; $display("FAIL reset_retire got %b want 0", retire); end
    vec++; if ({perf_instrs, perf_stalls} !== 64'd0) begin miscmp++; $display("FAIL reset_perf got %h/%h want 0/0", perf_instrs, perf_stalls); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vec++; if ({bus.req, bus.we, bus.addr} !== {2'b10, 32'h100}) begin miscmp++; $display("FAIL first_fetch got req=%b we=%b addr=%h want 1 0 00000100", bus.req, bus.we, bus.addr); end
    @(posedge clk); #1;
    @(negedge clk);
    vec++; if (pc !== 32'h104) begin miscmp++; $display("FAIL pc_after_fetch got %h want 00000104", pc); end
  endtask
  task automatic test_addi;
    int c = 2;
    logic r = retire;
    while (!r && c < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      c++;
      r = retire;
    end
    @(posedge clk); #1;
    vec++; if (c !== 4) begin miscmp++; $display("FAIL addi_latency got %0d want 4", c); end
  endtask
  task automatic test_store;
    int c;
    logic [31:0] fa;
    run(c, fa);
    vec++; if (c !== 4 || fa !== 32'h104) begin miscmp++; $display("FAIL sw_r5_timing got cyc=%0d fetch=%h want 4 00000104", c, fa); end
    vec++; if ({st_addr, st_data} !== {32'h10, 32'hFFFFFFFF}) begin miscmp++; $display("FAIL sw_r5_data got %h@%h want ffffffff@00000010", st_data, st_addr); end
  endtask
  task automatic test_load;
    int c;
    logic [31:0] fa;
    data_waits = 3;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        vec++; if (bus.addr !== 32'h108) begin miscmp++; $display("FAIL lw_fetch got %h want 00000108", bus.addr); end
      end
      if (i >= 4 && i <= 7) begin
        vec++; if ({bus.req, bus.we, bus.addr} !== {2'b10, 32'h40}) begin miscmp++; $display("FAIL lw_hold cyc %0d got req=%b we=%b addr=%h want 1 0 00000040", i, bus.req, bus.we, bus.addr); end
      end
      vec++; if (retire !== (i == 8)) begin miscmp++; $display("FAIL lw_retire cyc %0d got %b want %b", i, retire, i == 8); end
      @(posedge clk); #1;
    end
    data_waits = 0;
    vec++; if (perf_stalls !== (PERF ? 32'd3 : 32'd0)) begin miscmp++; $display("FAIL perf_stalls got %0d want %0d", perf_stalls, PERF ? 3 : 0); end
    vec++; if (perf_instrs !== (PERF ? 32'd3 : 32'd0)) begin miscmp++; $display("FAIL perf_instrs got %0d want %0d", perf_instrs, PERF ? 3 : 0); end
    run(c, fa);
    vec++; if (c !== 4 || st_data !== 32'hDEADBEEF) begin miscmp++; $display("FAIL lw_value got cyc=%0d data=%h want 4 deadbeef", c, st_data); end
  endtask
  task automatic test_add;
    int c;
    logic [31:0] fa;
    run(c, fa);
    vec++; if (c !== 4 || fa !== 32'h110) begin miscmp++; $display("FAIL add_timing got cyc=%0d fetch=%h want 4 00000110", c, fa); end
    run(c, fa);
    vec++; if (st_data !== 32'hDEADBEEE) begin miscmp++; $display("FAIL add_value got %h want deadbeee", st_data); end
    run(c, fa);
    vec++; if (c !== 3 || fa !== 32'h118) begin miscmp++; $display("FAIL j_timing got cyc=%0d fetch=%h want 3 00000118", c, fa); end
  endtask
  task automatic test_branch;
    int c;
    logic [31:0] fa;
    run(c, fa);
    vec++; if (c !== 3 || fa !== 32'h200) begin miscmp++; $display("FAIL beq_taken_first got cyc=%0d fetch=%h want 3 00000200", c, fa); end
    imem['h200 / 4] = ei(OP_BEQ, 7'd5, 7'd0, 12'hFFF);
    run(c, fa);
    vec++; if (c !== 3 || fa !== 32'h200) begin miscmp++; $display("FAIL beq_taken_target got cyc=%0d fetch=%h want 3 00000200", c, fa); end
    run(c, fa);
    vec++; if (fa !== 32'h204) begin miscmp++; $display("FAIL beq_not_taken got fetch=%h want 00000204", fa); end
  endtask
  task automatic test_jal;
    int c;
    logic [31:0] fa;
    imem['h40 / 4] = ei(OP_JR, 7'd127, 7'd0, 12'h000);
    run(c, fa);
    vec++; if (c !== 3 || fa !== 32'h300) begin miscmp++; $display("FAIL jal_timing got cyc=%0d fetch=%h want 3 00000300", c, fa); end
    run(c, fa);
    vec++; if (c !== 3 || fa !== 32'h40) begin miscmp++; $display("FAIL jal_target got cyc=%0d fetch=%h want 3 00000040", c, fa); end
    run(c, fa);
    vec++; if (fa !== 32'h304) begin miscmp++; $display("FAIL jr_return got fetch=%h want 00000304", fa); end
    vec++; if (st_data !== 32'h304) begin miscmp++; $display("FAIL jal_link got %h want 00000304", st_data); end
  endtask
  task automatic test_r0;
    int c;
    logic [31:0] fa;
    run(c, fa);
    run(c, fa);
    vec++; if ({st_addr, st_data} !== {32'h20, 32'h0}) begin miscmp++; $display("FAIL r0_zero got %h@%h want 00000000@00000020", st_data, st_addr); end
  endtask
  task automatic test_reset_mid_store;
    int s0 = st_cnt;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    vec++; if ({bus.req, bus.we, bus.addr} !== {2'b11, 32'h24}) begin miscmp++; $display("FAIL mid_store_mem got req=%b we=%b addr=%h want 1 1 00000024", bus.req, bus.we, bus.addr); end
    reset = 1'b1;
    force_rdy = 1'b1;
    #1;
    vec++; if ({retire, bus.req} !== 2'b00) begin miscmp++; $display("FAIL mid_store_gate got retire=%b req=%b want 0 0", retire, bus.req); end
    @(posedge clk); #1;
    reset = 1'b0;
    force_rdy = 1'b0;
    vec++; if (st_cnt !== s0) begin miscmp++; $display("FAIL mid_store_commit got %0d stores want %0d", st_cnt, s0); end
    vec++; if (pc !== 32'h100) begin miscmp++; $display("FAIL mid_store_pc got %h want 00000100", pc); end
    vec++; if ({perf_instrs, perf_stalls} !== 64'd0) begin miscmp++; $display("FAIL mid_store_perf got %h/%h want 0/0", perf_instrs, perf_stalls); end
    @(negedge clk);
    vec++; if ({bus.req, bus.we, bus.addr} !== {2'b10, 32'h100}) begin miscmp++; $display("FAIL refetch got req=%b we=%b addr=%h want 1 0 00000100", bus.req, bus.we, bus.addr); end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    imem['h100 / 4] = ei(OP_ADDI, 7'd0, 7'd5, 12'hFFF);
    imem['h104 / 4] = ei(OP_SW, 7'd0, 7'd5, 12'h010);
    imem['h108 / 4] = ei(OP_LW, 7'd0, 7'd6, 12'h040);
    imem['h10C / 4] = ei(OP_SW, 7'd0, 7'd6, 12'h014);
    imem['h110 / 4] = er(7'd5, 7'd6, 7'd7);
    imem['h114 / 4] = ei(OP_SW, 7'd0, 7'd7, 12'h018);
    imem['h118 / 4] = ej(OP_J, 26'h80);
    imem['h40 / 4] = 32'hDEADBEEF;
    imem['h200 / 4] = ei(OP_BEQ, 7'd0, 7'd0, 12'hFFF);
    imem['h204 / 4] = ej(OP_J, 26'hC0);
    imem['h300 / 4] = ej(OP_JAL, 26'h10);
    imem['h304 / 4] = ei(OP_SW, 7'd0, 7'd127, 12'h01C);
    imem['h308 / 4] = er(7'd5, 7'd5, 7'd0);
    imem['h30C / 4] = ei(OP_SW, 7'd0, 7'd0, 12'h020);
    imem['h310 / 4] = ei(OP_SW, 7'd0, 7'd5, 12'h024);
    test_reset;
    test_addi;
    test_store;
    test_load;
    test_add;
    test_branch;
    test_jal;
    test_r0;
    test_reset_mid_store;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
